// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: drives one shared full-adder cell LSB first,
// holding each bit for SETTLE_CYC cycles and carrying Co between bit steps.
module serial_add_ctrl #(
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE_CYC - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    next_idx;

  assign next_idx = idx + IW'(1);

  // fa_ci doubles as the carry register: during RUN it always holds the carry
  // into the current bit, and it is forced to 0 outside RUN.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; mixing in blocking assignments would make the
  // result depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      co    <= 1'b0;
      fa_a  <= 1'b0;
      fa_b  <= 1'b0;
      fa_ci <= 1'b0;
      idx   <= '0;
      cnt   <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= '0;
            cnt   <= '0;
            sum   <= '0;
            co    <= 1'b0;
            busy  <= 1'b1;
            fa_a  <= a[0];
            fa_b  <= b[0];
            fa_ci <= ci;
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt == LAST_CNT) begin
            sum[idx] <= fa_s;
            cnt      <= '0;
            if (idx == LAST_IDX) begin
              co    <= fa_co;
              done  <= 1'b1;
              fa_a  <= 1'b0;
              fa_b  <= 1'b0;
              fa_ci <= 1'b0;
              state <= DONE;
            end else begin
              // Next bit's operands and carry are launched on the same edge,
              // so the cell inputs change only at window boundaries.
              idx   <= next_idx;
              fa_a  <= a_reg[next_idx];
              fa_b  <= b_reg[next_idx];
              fa_ci <= fa_co;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          fa_a  <= 1'b0;
          fa_b  <= 1'b0;
          fa_ci <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that performs a WIDTH-bit addition on a single shared full-adder cell (A, B, Ci in; S, Co out), one bit per step, LSB first.
- Holds the carry between steps in a register and waits a programmable number of clock cycles per bit so the cell's gate delays settle.
- Assembles the sum and carry-out and signals completion with a one-cycle done pulse.
- Sits between a requesting datapath and one instance of the team's gate-level adder cell.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 1.
- SETTLE_CYC, 4, clock cycles each bit is held on the cell before sampling; must be ≥ 1.
- SETTLE_CYC × clock period must exceed the cell's worst-case Co delay of 30 ns: three gate levels at 10 ns each.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- ci  input  1  carry-in; captured on accepted start
- busy  output  1  high while in RUN or DONE
- done  output  1  one-cycle pulse; sum and co valid
- sum  output  WIDTH  result; holds until the next accepted start
- co  output  1  final carry-out; holds with sum
- fa_a  output  1  to cell A
- fa_b  output  1  to cell B
- fa_ci  output  1  to cell Ci
- fa_s  input  1  from cell S
- fa_co  input  1  from cell Co

Behaviour:
- Single clock; reset is synchronous, active-high, and takes priority over all other inputs.
- Reset values: state=IDLE, busy=0, done=0, sum=0, co=0, fa_a=fa_b=fa_ci=0, bit index=0, settle counter=0, carry register=0.
- Reset asserted mid-operation aborts immediately; the partial sum is discarded and sum/co clear to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - fa_* driven 0.
  - When start=1 at an edge: latch a, b; carry register ← ci; index ← 0; counter ← 0; sum ← 0; co ← 0; go to RUN.
- RUN:
  - fa_a=a_reg[index], fa_b=b_reg[index], fa_ci=carry register, all registered and stable for the whole SETTLE_CYC window.
  - Counter increments each cycle. At the edge where counter==SETTLE_CYC-1:
    - sum[index] ← fa_s; carry register ← fa_co; counter ← 0.
    - If index==WIDTH-1: co ← fa_co and go to DONE.
    - Otherwise index ← index+1.
- DONE:
  - done=1 for exactly one cycle; fa_* driven 0; next state IDLE.
- Latency: with start accepted at edge 0, done is high in the cycle after edge WIDTH×SETTLE_CYC. Defaults give 32 cycles.
- Minimum start-to-start spacing is WIDTH×SETTLE_CYC+2 edges, since start is accepted only in IDLE.
- start while busy=1, including during DONE: ignored; no state change and no queueing.
- a, b and ci may change freely after acceptance; the internal copies are used.
- sum bits update progressively during RUN and are valid only when done=1 or later.
- Arithmetic is unsigned modulo 2^WIDTH; co is the true carry out of bit WIDTH-1.
- WIDTH=1 is legal: one bit step, then DONE.
- SETTLE_CYC=1 is legal: one bit per cycle.
- No combinational path from any input to any output; all outputs registered.

Test Plan:
- a=8'h5A, b=8'h3C, ci=0, start 1 cycle -> busy rises next cycle; done pulses exactly 32 cycles after start edge; sum=8'h96, co=0.
- a=8'hFF, b=8'h01, ci=0 -> full carry ripple through all bits; sum=8'h00, co=1. Also check fa_ci=1 from bit 1 onward.
- a=8'hFF, b=8'h00, ci=1 -> sum=8'h00, co=1. Then a=8'h00, b=8'h00, ci=0 back-to-back at minimum spacing -> sum=8'h00, co=0, done pulse once per op.
- Pulse start again at cycles 5 and 32 of an op on 8'h12+8'h34 -> both ignored; single done pulse; sum=8'h46, co=0.
- Assert reset for 1 cycle at cycle 13 of an op on 8'hAA+8'h55 -> next cycle busy=0, done=0, sum=0, co=0, fa_*=0. A new start of 8'h01+8'h01 then yields sum=8'h02.
- Bench monitor checks fa_a/fa_b/fa_ci never change within a SETTLE_CYC window. Rerun the first case with SETTLE_CYC=1 -> done after 8 cycles, same result.
